// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: port indices and default widths.
// The optional bus-lock feature is enabled by defining DMEM_ARB_LOCK_EN.
package dmem_arb_pkg;

  localparam bit PORT_M0 = 1'b0;
  localparam bit PORT_M1 = 1'b1;

  localparam int DEF_AW = 11;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-way round-robin arbiter holding the priority pointer and, when
// DMEM_ARB_LOCK_EN is defined, the lock owner state.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  output logic [1:0] gnt
);

  logic pri_q;
  logic pri_d;
  logic win;
  logic any_req;
`ifdef DMEM_ARB_LOCK_EN
  logic locked_q;
  logic locked_d;
  logic owner_q;
  logic owner_d;
`endif

  always_comb begin
    gnt     = 2'b00;
    pri_d   = pri_q;
    any_req = |req;
    win     = (req == 2'b11) ? pri_q : req[PORT_M1];
`ifdef DMEM_ARB_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
`endif
    if (!RST) begin
`ifdef DMEM_ARB_LOCK_EN
      // The owner keeps the memory until it shows LOCK low, granted or idle.
      if (locked_q) begin
        gnt[owner_q] = req[owner_q];
        locked_d     = lock[owner_q];
      end else if (any_req) begin
        gnt[win] = 1'b1;
        if (lock[win]) begin
          locked_d = 1'b1;
          owner_d  = win;
        end else begin
          pri_d = ~win;
        end
      end
`else
      if (any_req) begin
        gnt[win] = 1'b1;
        pri_d    = ~win;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pri_q <= PORT_M0;
`ifdef DMEM_ARB_LOCK_EN
      locked_q <= 1'b0;
      owner_q  <= PORT_M0;
`endif
    end else begin
      pri_q <= pri_d;
`ifdef DMEM_ARB_LOCK_EN
      locked_q <= locked_d;
      owner_q  <= owner_d;
`endif
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Two-master data-memory arbiter: round-robin grant, address/data mux and
// per-port read-valid pipeline. Define DMEM_ARB_LOCK_EN for the M0/M1 LOCK inputs.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          M0_REQ,
  input  logic          M0_WE,
  input  logic [AW-1:0] M0_A,
  input  logic [DW-1:0] M0_D,
  input  logic          M1_REQ,
  input  logic          M1_WE,
  input  logic [AW-1:0] M1_A,
  input  logic [DW-1:0] M1_D,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          M0_LOCK,
  input  logic          M1_LOCK,
`endif
  output logic          M0_GNT,
  output logic          M1_GNT,
  output logic          M0_RVALID,
  output logic          M1_RVALID,
  output logic [DW-1:0] M0_Q,
  output logic [DW-1:0] M1_Q,
  output logic [AW-1:0] DA,
  output logic [DW-1:0] DD,
  output logic          DE,
  input  logic [DW-1:0] DQ
);

  logic [1:0]    gnt;
  logic [1:0]    rv_q;
  logic [AW-1:0] da_q;

  rr_arb2 u_arb (
    .CLK (CLK),
    .RST (RST),
    .req ({M1_REQ, M0_REQ}),
`ifdef DMEM_ARB_LOCK_EN
    .lock({M1_LOCK, M0_LOCK}),
`endif
    .gnt (gnt)
  );

  assign M0_GNT = gnt[PORT_M0];
  assign M1_GNT = gnt[PORT_M1];

  always_comb begin
    DA = da_q;
    DD = '0;
    DE = 1'b0;
    if (gnt[PORT_M0]) begin
      DA = M0_A;
      DD = M0_D;
      DE = M0_WE;
    end else if (gnt[PORT_M1]) begin
      DA = M1_A;
      DD = M1_D;
      DE = M1_WE;
    end
  end

  // Remember the owner of each read so returning data goes to the right port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      da_q <= '0;
      rv_q <= 2'b00;
    end else begin
      if (|gnt) da_q <= DA;
      rv_q[PORT_M0] <= gnt[PORT_M0] & ~M0_WE;
      rv_q[PORT_M1] <= gnt[PORT_M1] & ~M1_WE;
    end
  end

  assign M0_RVALID = rv_q[PORT_M0] & ~RST;
  assign M1_RVALID = rv_q[PORT_M1] & ~RST;
  assign M0_Q      = DQ;
  assign M1_Q      = DQ;

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: reset, single reads/writes, contention,
// reset during a read and, with DMEM_ARB_LOCK_EN, the lock sequence.
module tb_dmem_arb;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          CLK;
  logic          RST;
  logic          M0_REQ, M1_REQ, M0_WE, M1_WE;
  logic [AW-1:0] M0_A, M1_A;
  logic [DW-1:0] M0_D, M1_D;
  logic          M0_GNT, M1_GNT, M0_RVALID, M1_RVALID;
  logic [DW-1:0] M0_Q, M1_Q;
  logic [AW-1:0] DA;
  logic [DW-1:0] DD;
  logic          DE;
  logic [DW-1:0] DQ;
`ifdef DMEM_ARB_LOCK_EN
  logic          M0_LOCK, M1_LOCK;
`endif

  int total;
  int bad;

  dmem_arb #(.AW(AW), .DW(DW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .M0_REQ   (M0_REQ),
    .M0_WE    (M0_WE),
    .M0_A     (M0_A),
    .M0_D     (M0_D),
    .M1_REQ   (M1_REQ),
    .M1_WE    (M1_WE),
    .M1_A     (M1_A),
    .M1_D     (M1_D),
`ifdef DMEM_ARB_LOCK_EN
    .M0_LOCK  (M0_LOCK),
    .M1_LOCK  (M1_LOCK),
`endif
    .M0_GNT   (M0_GNT),
    .M1_GNT   (M1_GNT),
    .M0_RVALID(M0_RVALID),
    .M1_RVALID(M1_RVALID),
    .M0_Q     (M0_Q),
    .M1_Q     (M1_Q),
    .DA       (DA),
    .DD       (DD),
    .DE       (DE),
    .DQ       (DQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs on the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic [DW-1:0] dq);
    @(negedge CLK);
    RST = rst;
    M0_REQ = r0; M0_WE = w0; M0_A = a0; M0_D = d0;
    M1_REQ = r1; M1_WE = w1; M1_A = a1; M1_D = d1;
    DQ = dq;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST = 1'b1;
    M0_REQ = 0; M0_WE = 0; M0_A = '0; M0_D = '0;
    M1_REQ = 0; M1_WE = 0; M1_A = '0; M1_D = '0;
    DQ = '0;
`ifdef DMEM_ARB_LOCK_EN
    M0_LOCK = 0; M1_LOCK = 0;
`endif

    // Requests during reset must not be granted.
    applyStimulus(1, 0,0,'0,'0, 0,0,'0,'0, '0);
    applyStimulus(1, 1,1,11'h00A,32'h1, 1,0,11'h00B,'0, '0);
    checkOutput("rst_m0_gnt", {31'b0, M0_GNT}, 32'd0);
    checkOutput("rst_m1_gnt", {31'b0, M1_GNT}, 32'd0);
    checkOutput("rst_de", {31'b0, DE}, 32'd0);
    checkOutput("rst_m0_rvalid", {31'b0, M0_RVALID}, 32'd0);
    applyStimulus(0, 0,0,'0,'0, 0,0,'0,'0, '0);
    checkOutput("rst_da", {21'b0, DA}, 32'd0);

    // Single M0 read.
    applyStimulus(0, 1,0,11'h005,'0, 0,0,'0,'0, '0);
    checkOutput("rd_m0_gnt", {31'b0, M0_GNT}, 32'd1);
    checkOutput("rd_m1_gnt", {31'b0, M1_GNT}, 32'd0);
    checkOutput("rd_da", {21'b0, DA}, 32'h005);
    checkOutput("rd_de", {31'b0, DE}, 32'd0);
    applyStimulus(0, 0,0,'0,'0, 0,0,'0,'0, 32'h11223344);
    checkOutput("rd_m0_rvalid", {31'b0, M0_RVALID}, 32'd1);
    checkOutput("rd_m0_q", M0_Q, 32'h11223344);
    checkOutput("rd_m1_rvalid", {31'b0, M1_RVALID}, 32'd0);
    checkOutput("rd_da_hold", {21'b0, DA}, 32'h005);
    applyStimulus(0, 0,0,'0,'0, 0,0,'0,'0, '0);
    checkOutput("rd_pulse_once", {31'b0, M0_RVALID}, 32'd0);

    // Contention straight after reset alternates M0, M1, M0, M1.
    applyStimulus(1, 0,0,'0,'0, 0,0,'0,'0, '0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1,1,11'h010,32'hDEADBEEF, 1,0,11'h020,'0, 32'hA5A50000 + k);
      checkOutput($sformatf("rr_m0_gnt_%0d", k), {31'b0, M0_GNT}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_m1_gnt_%0d", k), {31'b0, M1_GNT}, (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_de_%0d", k), {31'b0, DE}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_da_%0d", k), {21'b0, DA}, (k % 2 == 0) ? 32'h010 : 32'h020);
      checkOutput($sformatf("rr_m1_rvalid_%0d", k), {31'b0, M1_RVALID}, (k == 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_m0_rvalid_%0d", k), {31'b0, M0_RVALID}, 32'd0);
      if (k % 2 == 0) checkOutput($sformatf("rr_dd_%0d", k), DD, 32'hDEADBEEF);
    end
    applyStimulus(0, 0,0,'0,'0, 0,0,'0,'0, 32'hA5A50004);
    checkOutput("rr_m1_rvalid_tail", {31'b0, M1_RVALID}, 32'd1);
    checkOutput("rr_m1_q_tail", M1_Q, 32'hA5A50004);

    // M0 alone, then M1 alone write to the top address; contention then favours M0.
    applyStimulus(0, 1,1,11'h001,32'h12345678, 0,0,'0,'0, '0);
    checkOutput("m0w_gnt", {31'b0, M0_GNT}, 32'd1);
    checkOutput("m0w_de", {31'b0, DE}, 32'd1);
    applyStimulus(0, 0,0,'0,'0, 1,1,11'h7FF,32'hFFFFFFFF, '0);
    checkOutput("m1w_gnt", {31'b0, M1_GNT}, 32'd1);
    checkOutput("m1w_m0_gnt", {31'b0, M0_GNT}, 32'd0);
    checkOutput("m1w_da", {21'b0, DA}, 32'h7FF);
    checkOutput("m1w_de", {31'b0, DE}, 32'd1);
    checkOutput("m1w_dd", DD, 32'hFFFFFFFF);
    applyStimulus(0, 1,0,11'h003,'0, 1,0,11'h004,'0, 32'h0BADF00D);
    checkOutput("m1w_no_rv1", {31'b0, M1_RVALID}, 32'd0);
    checkOutput("m1w_no_rv0", {31'b0, M0_RVALID}, 32'd0);
    checkOutput("pri_m0_gnt", {31'b0, M0_GNT}, 32'd1);
    checkOutput("pri_m1_gnt", {31'b0, M1_GNT}, 32'd0);
    checkOutput("pri_da", {21'b0, DA}, 32'h003);
    applyStimulus(0, 1,0,11'h003,'0, 1,0,11'h004,'0, 32'hCAFE0003);
    checkOutput("pri2_m1_gnt", {31'b0, M1_GNT}, 32'd1);
    checkOutput("pri2_da", {21'b0, DA}, 32'h004);
    checkOutput("pri2_m0_rvalid", {31'b0, M0_RVALID}, 32'd1);
    checkOutput("pri2_m0_q", M0_Q, 32'hCAFE0003);
    applyStimulus(0, 0,0,'0,'0, 0,0,'0,'0, 32'hCAFE0004);
    checkOutput("pri3_m1_rvalid", {31'b0, M1_RVALID}, 32'd1);
    checkOutput("pri3_m0_rvalid", {31'b0, M0_RVALID}, 32'd0);

    // Reset the cycle after an M0 read grant drops its data and restores priority to M0.
    applyStimulus(0, 1,0,11'h008,'0, 0,0,'0,'0, '0);
    checkOutput("rstrd_gnt", {31'b0, M0_GNT}, 32'd1);
    applyStimulus(1, 1,0,11'h008,'0, 1,0,11'h009,'0, 32'h55555555);
    checkOutput("rstrd_m0_rvalid", {31'b0, M0_RVALID}, 32'd0);
    checkOutput("rstrd_m0_gnt", {31'b0, M0_GNT}, 32'd0);
    checkOutput("rstrd_m1_gnt", {31'b0, M1_GNT}, 32'd0);
    checkOutput("rstrd_de", {31'b0, DE}, 32'd0);
    applyStimulus(0, 0,0,'0,'0, 0,0,'0,'0, '0);
    checkOutput("rstrd_da_clr", {21'b0, DA}, 32'd0);
    checkOutput("rstrd_rv_after", {31'b0, M0_RVALID}, 32'd0);
    applyStimulus(0, 1,0,11'h00C,'0, 1,0,11'h00D,'0, '0);
    checkOutput("rstrd_pri_m0", {31'b0, M0_GNT}, 32'd1);
    checkOutput("rstrd_pri_m1", {31'b0, M1_GNT}, 32'd0);

`ifdef DMEM_ARB_LOCK_EN
    // M1 holds the lock for three grants while M0 keeps requesting.
    applyStimulus(1, 0,0,'0,'0, 0,0,'0,'0, '0);
    M1_LOCK = 1'b1;
    applyStimulus(0, 0,0,'0,'0, 1,0,11'h030,'0, '0);
    checkOutput("lk_first_m1", {31'b0, M1_GNT}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1,0,11'h031,'0, 1,0,11'h030,'0, '0);
      checkOutput($sformatf("lk_m0_blocked_%0d", k), {31'b0, M0_GNT}, 32'd0);
      checkOutput($sformatf("lk_m1_held_%0d", k), {31'b0, M1_GNT}, 32'd1);
    end
    M1_LOCK = 1'b0;
    applyStimulus(0, 1,0,11'h031,'0, 1,0,11'h030,'0, '0);
    checkOutput("lk_release_m1", {31'b0, M1_GNT}, 32'd1);
    checkOutput("lk_release_m0", {31'b0, M0_GNT}, 32'd0);
    applyStimulus(0, 1,0,11'h031,'0, 1,0,11'h030,'0, '0);
    checkOutput("lk_after_m0", {31'b0, M0_GNT}, 32'd1);
    checkOutput("lk_after_m1", {31'b0, M1_GNT}, 32'd0);
`endif

    applyStimulus(0, 0,0,'0,'0, 0,0,'0,'0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
